// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared FSM encodings and sizing defaults for the store buffer
package store_buffer_pkg;

    typedef enum logic {
        SB_NORMAL = 1'b0,
        SB_FLUSH  = 1'b1
    } sb_state_t;

    localparam int SB_DEPTH = 4;
    localparam int WADDR_W  = 30;

endpackage

// File: rtl/store_buffer_sb_match.sv
// rtl/store_buffer_sb_match.sv - word-address compare of one key against all buffer entries
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [WADDR_W-1:0]            key,
    input  logic [DEPTH-1:0][WADDR_W-1:0] entries,
    input  logic [DEPTH-1:0]              valid,
    output logic                          hit,
    output logic [IDX_W-1:0]              hit_idx
);

    logic [DEPTH-1:0] onehot;

    // coalescing keeps addresses unique, so at most one bit of onehot is set
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            onehot[i] = valid[i] && (entries[i] == key);
            if (onehot[i]) begin
                hit_idx = IDX_W'(i);
            end
        end
        hit = |onehot;
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - write-back store buffer with load forwarding, coalescing and flush drain
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_mem_read,
    input  logic             cpu_mem_write,
    input  logic [31:0]      cpu_address,
    input  logic [31:0]      cpu_write_data,
    input  logic             flush_req,
    output logic [31:0]      cpu_read_data,
    output logic             stall,
    output logic             flush_done,
    output logic [CNT_W-1:0] sb_count,
    output logic             mem_read,
    output logic             mem_write,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_write_data,
    input  logic [31:0]      mem_read_data
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0][WADDR_W-1:0] ent_addr;
    logic [DEPTH-1:0][31:0]        ent_data;
    logic [DEPTH-1:0]              ent_valid;
    logic [IDX_W-1:0]              head;
    logic [IDX_W-1:0]              tail;
    logic [CNT_W-1:0]              count;
    logic                          flush_done_q;
    sb_state_t                     state;
    sb_state_t                     state_next;

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             full;
    logic             rd_req;
    logic             wr_req;
    logic             rd_miss;
    logic             load_hit;
    logic             drain;
    logic             head_draining;
    logic             wr_ok;
    logic             coalesce;
    logic             enqueue;

    sb_match #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_match (
        .key     (cpu_address[31:2]),
        .entries (ent_addr),
        .valid   (ent_valid),
        .hit     (hit),
        .hit_idx (hit_idx)
    );

    // Read and write both high still arbitrates the port like a load but returns no data
    assign full          = (count == CNT_W'(DEPTH));
    assign rd_req        = cpu_mem_read && (state == SB_NORMAL) && !reset;
    assign wr_req        = cpu_mem_write && (state == SB_NORMAL) && !reset;
    assign rd_miss       = rd_req && !hit;
    assign load_hit      = rd_req && !cpu_mem_write && hit;
    assign drain         = (count != '0) && !rd_miss && !reset;
    assign head_draining = drain && (hit_idx == head);
    assign wr_ok         = wr_req && !full;
    assign coalesce      = wr_ok && hit && !head_draining;
    assign enqueue       = wr_ok && !coalesce;

    assign mem_read       = rd_miss;
    assign mem_write      = drain;
    assign mem_address    = rd_miss ? cpu_address : (drain ? {ent_addr[head], 2'b00} : '0);
    assign mem_write_data = drain ? ent_data[head] : '0;
    assign cpu_read_data  = load_hit ? ent_data[hit_idx] :
                            (rd_miss && !cpu_mem_write) ? mem_read_data : '0;
    assign sb_count       = count;
    assign flush_done     = flush_done_q;

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            SB_NORMAL: begin
                stall = cpu_mem_write && full && !reset;
                if (flush_req && !reset) begin
                    state_next = SB_FLUSH;
                end
            end
            SB_FLUSH: begin
                stall = !reset;
                if ((count == '0) || ((count == CNT_W'(1)) && drain)) begin
                    state_next = SB_NORMAL;
                end
            end
            default: state_next = SB_NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= SB_NORMAL;
            count        <= '0;
            head         <= '0;
            tail         <= '0;
            ent_valid    <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state        <= state_next;
            flush_done_q <= (state == SB_FLUSH) && (state_next == SB_NORMAL);
            if (drain) begin
                ent_valid[head] <= 1'b0;
                head            <= head + IDX_W'(1);
            end
            if (enqueue) begin
                ent_addr[tail]  <= cpu_address[31:2];
                ent_data[tail]  <= cpu_write_data;
                ent_valid[tail] <= 1'b1;
                tail            <= tail + IDX_W'(1);
            end
            if (coalesce) begin
                ent_data[hit_idx] <= cpu_write_data;
            end
            case ({enqueue, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;

    logic        clk;
    logic        reset;
    logic        cpu_mem_read;
    logic        cpu_mem_write;
    logic [31:0] cpu_address;
    logic [31:0] cpu_write_data;
    logic        flush_req;
    logic [31:0] cpu_read_data;
    logic        stall;
    logic        flush_done;
    logic [2:0]  sb_count;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int vectors;
    int miscompares;

    store_buffer #(.DEPTH(4), .CNT_W(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_mem_read   (cpu_mem_read),
        .cpu_mem_write  (cpu_mem_write),
        .cpu_address    (cpu_address),
        .cpu_write_data (cpu_write_data),
        .flush_req      (flush_req),
        .cpu_read_data  (cpu_read_data),
        .stall          (stall),
        .flush_done     (flush_done),
        .sb_count       (sb_count),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // memory contents: every word reads back as its address xor a fixed pattern
    assign mem_read_data = mem_address ^ 32'hDEAD_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic fl);
        cpu_mem_read   = rd;
        cpu_mem_write  = wr;
        cpu_address    = a;
        cpu_write_data = d;
        flush_req      = fl;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_write(input string tag, input logic [31:0] a, input logic [31:0] d);
        check_vec({tag, "_we"}, mem_write, 1);
        check_vec({tag, "_addr"}, mem_address, a);
        check_vec({tag, "_data"}, mem_write_data, d);
    endtask

    initial begin
        int stall_cycles;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        set_in(0, 0, 32'h0, 32'h0, 0);
        tick;
        tick;

        // reset state
        mid;
        check_vec("rst_count", sb_count, 0);
        check_vec("rst_stall", stall, 0);
        check_vec("rst_flush_done", flush_done, 0);
        check_vec("rst_mem_write", mem_write, 0);
        check_vec("rst_mem_read", mem_read, 0);
        check_vec("rst_mem_addr", mem_address, 0);
        check_vec("rst_rdata", cpu_read_data, 0);
        tick;
        reset = 1'b0;

        // store then drain
        set_in(0, 1, 32'h10, 32'hAAAA_5555, 0);
        mid;
        check_vec("sd_no_write_yet", mem_write, 0);
        tick;
        set_in(0, 0, 32'h0, 32'h0, 0);
        mid;
        check_vec("sd_count1", sb_count, 1);
        check_write("sd_drain", 32'h10, 32'hAAAA_5555);
        tick;
        mid;
        check_vec("sd_count0", sb_count, 0);
        check_vec("sd_idle", mem_write, 0);
        tick;

        // forwarding from the head while it drains
        set_in(0, 1, 32'h20, 32'h1234, 0);
        tick;
        set_in(1, 0, 32'h22, 32'h0, 0);
        mid;
        check_vec("fw_rdata", cpu_read_data, 32'h1234);
        check_vec("fw_mem_read", mem_read, 0);
        check_write("fw_drain", 32'h20, 32'h1234);
        tick;
        // load miss returns memory data
        set_in(1, 0, 32'h50, 32'h0, 0);
        mid;
        check_vec("miss_mem_read", mem_read, 1);
        check_vec("miss_addr", mem_address, 32'h50);
        check_vec("miss_rdata", cpu_read_data, 32'hDEAD_0050);
        check_vec("miss_count", sb_count, 0);
        tick;

        // coalescing behind a blocked drain
        set_in(1, 1, 32'h40, 32'h40, 0);
        mid;
        check_vec("co_illegal_rdata", cpu_read_data, 0);
        check_vec("co_block", mem_write, 0);
        tick;
        set_in(1, 1, 32'h30, 32'h1, 0);
        tick;
        set_in(1, 1, 32'h30, 32'h2, 0);
        mid;
        check_vec("co_hit_no_read", mem_read, 0);
        check_write("co_first", 32'h40, 32'h40);
        tick;
        set_in(0, 0, 32'h0, 32'h0, 0);
        mid;
        check_vec("co_count", sb_count, 1);
        check_write("co_merged", 32'h30, 32'h2);
        tick;

        // fill to full, then a store that must stall for one cycle
        for (int i = 0; i < 4; i++) begin
            set_in(1, 1, 32'h100 + 32'(4 * i), 32'(i + 1), 0);
            tick;
        end
        set_in(0, 1, 32'h110, 32'h5, 0);
        mid;
        check_vec("full_count", sb_count, 4);
        check_vec("full_stall", stall, 1);
        check_write("full_w0", 32'h100, 32'h1);
        tick;
        mid;
        check_vec("full_stall_release", stall, 0);
        check_vec("full_count3", sb_count, 3);
        check_write("full_w1", 32'h104, 32'h2);
        tick;
        set_in(0, 0, 32'h0, 32'h0, 0);
        for (int i = 2; i < 5; i++) begin
            mid;
            check_write($sformatf("full_w%0d", i), 32'h100 + 32'(4 * i), 32'(i + 1));
            tick;
        end
        mid;
        check_vec("full_empty", sb_count, 0);
        tick;

        // flush of three entries
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 32'h200 + 32'(4 * i), 32'hA + 32'(i), 0);
            tick;
        end
        set_in(1, 0, 32'h300, 32'h0, 1);
        mid;
        check_vec("fl_req_no_stall", stall, 0);
        check_vec("fl_req_blocked", mem_write, 0);
        tick;
        set_in(0, 0, 32'h0, 32'h0, 0);
        stall_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            mid;
            if (stall) stall_cycles++;
            check_write($sformatf("fl_w%0d", i), 32'h200 + 32'(4 * i), 32'hA + 32'(i));
            check_vec($sformatf("fl_done_early%0d", i), flush_done, 0);
            tick;
        end
        mid;
        check_vec("fl_stall_cycles", 32'(stall_cycles), 3);
        check_vec("fl_done", flush_done, 1);
        check_vec("fl_stall_off", stall, 0);
        check_vec("fl_count", sb_count, 0);
        tick;
        mid;
        check_vec("fl_done_pulse", flush_done, 0);
        tick;

        // flush of an empty buffer completes after one FLUSH cycle
        set_in(0, 0, 32'h0, 32'h0, 1);
        tick;
        set_in(0, 0, 32'h0, 32'h0, 0);
        mid;
        check_vec("fl0_stall", stall, 1);
        check_vec("fl0_no_write", mem_write, 0);
        tick;
        mid;
        check_vec("fl0_done", flush_done, 1);
        check_vec("fl0_stall_off", stall, 0);
        tick;

        // reset in the middle of a flush discards buffered stores
        set_in(1, 1, 32'h400, 32'h11, 0);
        tick;
        set_in(1, 1, 32'h404, 32'h22, 0);
        tick;
        set_in(1, 0, 32'h500, 32'h0, 1);
        tick;
        set_in(0, 0, 32'h0, 32'h0, 0);
        mid;
        check_vec("rf_count", sb_count, 2);
        check_vec("rf_stall", stall, 1);
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        mid;
        check_vec("rf_count0", sb_count, 0);
        check_vec("rf_stall0", stall, 0);
        check_vec("rf_no_write", mem_write, 0);
        tick;
        mid;
        check_vec("rf_still_idle", mem_write, 0);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
